ntt_butterfly_pipe: RTL and testbench

Pipelined Cooley-Tukey NTT butterfly that sits directly downstream of the combinational modular `multiplier`. It accepts coefficient pair (a, b) and a twiddle factor w. It instantiates `multiplier` to form t = (w*b) mod q, then produces x = (a + t) mod q and y = (a - t) mod q. It has valid/ready handshakes on both sides, 3-stage latency and full throughput, and feeds the NTT stage memory write-back.

---
 rtl/ntt_butterfly_pipe.sv | 116 +++++++++++
 tb/tb_ntt_butterfly_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_pipe.sv
// Three-stage pipelined Cooley-Tukey NTT butterfly: x = (a + w*b) mod q, y = (a - w*b) mod q.
// Valid/ready on both sides, bubble-collapsing stages, full throughput.

module multiplier #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] twiddle_factor,
    input  logic [DATA_W-1:0] modulus,
    output logic [DATA_W-1:0] result
);
    logic [2*DATA_W-1:0] prod;

    assign prod   = {{DATA_W{1'b0}}, data_in} * {{DATA_W{1'b0}}, twiddle_factor};
    assign result = DATA_W'(prod % {{DATA_W{1'b0}}, modulus});
endmodule

// Handshake rule: a word moves across an interface on a rising edge where valid && ready
// are both high; a producer holding valid keeps its data stable until that edge.
module ntt_butterfly_pipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] modulus,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] twiddle_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic              busy
);
    logic              v1, v2, v3;
    logic              rdy_en;
    logic              ld1, ld2, ld3;
    logic              out_xfer;
    logic [DATA_W-1:0] a1, b1, w1;
    logic [DATA_W-1:0] a2, t2;
    logic [DATA_W-1:0] x3, y3;
    logic [DATA_W-1:0] t1;
    logic [DATA_W:0]   sum_w, q_w, a_w, t_w;
    logic [DATA_W-1:0] x_next, y_next;

    multiplier #(.DATA_W(DATA_W)) u_mul (
        .data_in        (b1),
        .twiddle_factor (w1),
        .modulus        (modulus),
        .result         (t1)
    );

    // rdy_en keeps in_ready low until the first clock after reset release.
    assign ld3      = v2 && (!v3 || out_ready);
    assign ld2      = v1 && (!v2 || ld3);
    assign in_ready = rdy_en && (!v1 || ld2);
    assign ld1      = in_valid && in_ready;
    assign out_xfer = v3 && out_ready;

    assign out_valid = v3;
    assign x_out     = x3;
    assign y_out     = y3;
    assign busy      = v1 | v2 | v3;

    assign a_w    = {1'b0, a2};
    assign t_w    = {1'b0, t2};
    assign q_w    = {1'b0, modulus};
    assign sum_w  = a_w + t_w;
    assign x_next = DATA_W'((sum_w >= q_w) ? sum_w - q_w : sum_w);
    assign y_next = DATA_W'((a_w >= t_w) ? a_w - t_w : a_w + q_w - t_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            a1     <= '0;
            b1     <= '0;
            w1     <= '0;
            a2     <= '0;
            t2     <= '0;
            x3     <= '0;
            y3     <= '0;
        end else begin
            rdy_en <= 1'b1;

            if (ld1) begin
                v1 <= 1'b1;
                a1 <= a_in;
                b1 <= b_in;
                w1 <= twiddle_in;
            end else if (ld2) begin
                v1 <= 1'b0;
            end

            if (ld2) begin
                v2 <= 1'b1;
                a2 <= a1;
                t2 <= t1;
            end else if (ld3) begin
                v2 <= 1'b0;
            end

            if (ld3) begin
                v3 <= 1'b1;
                x3 <= x_next;
                y3 <= y_next;
            end else if (out_xfer) begin
                v3 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Directed and randomized checks of ntt_butterfly_pipe against a plain modular-arithmetic model.

module tb_ntt_butterfly_pipe;
    localparam int DATA_W = 32;
    localparam int Q      = 7681;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] modulus;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a_in, b_in, twiddle_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] x_out, y_out;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*DATA_W-1:0] exp_q[$];

    ntt_butterfly_pipe #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .modulus    (modulus),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .twiddle_in (twiddle_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .x_out      (x_out),
        .y_out      (y_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*DATA_W-1:0] bfly(longint unsigned a, longint unsigned b,
                                                 longint unsigned w, longint unsigned q);
        longint unsigned t, x, y;
        t = (w * b) % q;
        x = (a + t) % q;
        y = (a + q - t) % q;
        return {x[DATA_W-1:0], y[DATA_W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic directed(input int a, input int b, input int w, input int ex, input int ey);
        @(negedge clk);
        in_valid = 1'b1; a_in = a; b_in = b; twiddle_in = w; out_ready = 1'b1;
        #1 chk("dir_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("dir_lat_e1", out_valid, 0);
        @(negedge clk);
        chk("dir_lat_e2", out_valid, 0);
        @(negedge clk);
        chk("dir_lat_e3", out_valid, 1);
        chk("dir_x", x_out, ex);
        chk("dir_y", y_out, ey);
        @(negedge clk);
        chk("dir_one_cycle", out_valid, 0);
    endtask

    initial begin
        int accepted, sent, recvd, cyc;
        logic [2*DATA_W-1:0] e;
        logic [DATA_W-1:0] held_x;
        logic prev_stall;
        logic [DATA_W-1:0] prev_x, prev_y;

        rst_n = 1'b0; modulus = Q; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; twiddle_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready_pre", in_ready, 0);
        @(negedge clk);
        chk("rst_in_ready_post", in_ready, 1);

        directed(6, 6, 1, 12, 0);
        directed(100, 7679, 4298, 6866, 1015);
        directed(7680, 1, 1, 0, 7679);

        // Stall: fill with out_ready low.
        accepted = 0;
        held_x = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b0;
            a_in = $urandom_range(0, Q - 1); b_in = $urandom_range(0, Q - 1);
            twiddle_in = $urandom_range(0, Q - 1);
            if (i == 5) held_x = x_out;
            #1;
            if (in_ready) begin
                accepted++;
                exp_q.push_back(bfly(a_in, b_in, twiddle_in, Q));
            end
        end
        chk("stall_accepted", accepted, 3);
        chk("stall_in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_out_valid", out_valid, 1);
        chk("stall_x_stable", x_out, held_x);
        out_ready = 1'b1;
        #1 chk("stall_ready_comb", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("drain_valid", out_valid, 1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            chk("drain_x", x_out, e[2*DATA_W-1:DATA_W]);
            chk("drain_y", y_out, e[DATA_W-1:0]);
            @(negedge clk);
        end
        chk("drain_no_dup", out_valid, 0);

        // Random stream with random backpressure.
        sent = 0; recvd = 0; cyc = 0; prev_stall = 1'b0; prev_x = '0; prev_y = '0;
        exp_q.delete();
        while ((sent < 16 || exp_q.size() > 0) && cyc < 500) begin
            in_valid  = (sent < 16) && ($urandom_range(0, 3) != 0);
            a_in = $urandom_range(0, Q - 1); b_in = $urandom_range(0, Q - 1);
            twiddle_in = $urandom_range(0, Q - 1);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                chk("rnd_hold_valid", out_valid, 1);
                chk("rnd_hold_x", x_out, prev_x);
                chk("rnd_hold_y", y_out, prev_y);
            end
            if (out_valid && out_ready) begin
                recvd++;
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_x", x_out, e[2*DATA_W-1:DATA_W]);
                    chk("rnd_y", y_out, e[DATA_W-1:0]);
                end
            end
            if (in_valid && in_ready) begin
                sent++;
                exp_q.push_back(bfly(a_in, b_in, twiddle_in, Q));
            end
            prev_stall = out_valid && !out_ready;
            prev_x = x_out; prev_y = y_out;
            @(negedge clk);
            cyc++;
        end
        chk("rnd_timeout", (cyc < 500), 1);
        chk("rnd_count", recvd, 16);
        in_valid = 1'b0;

        // Reset with two entries in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a_in = $urandom_range(0, Q - 1); b_in = $urandom_range(0, Q - 1);
            twiddle_in = $urandom_range(0, Q - 1);
            #1 chk("mid_accept", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) accepted++;
        end
        chk("mid_no_stale", accepted, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
